// File: rtl/clkdiv_switch_ctrl.sv
// rtl/clkdiv_switch_ctrl.sv - glitch-free clock divider with drain-before-switch ratio change
// Ratio changes wait for the running period to finish, then spend one LOAD cycle with the output low.
module clkdiv_switch_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_enable,
  input  logic             i_cfg_valid,
  input  logic [1:0]       i_cfg_sel,
  output logic             o_cfg_ready,
  output logic             o_busy,
  output logic [1:0]       o_active_sel,
  output logic [WIDTH-1:0] o_count,
  output logic             o_count_end,
  output logic             o_div_clk
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_LOAD  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             div_q, div_d;
  logic [1:0]       active_sel_q, active_sel_d;
  logic [1:0]       pending_q, pending_d;

  logic [WIDTH-1:0] term_cnt;
  logic [WIDTH-1:0] half_cnt;
  logic [WIDTH-1:0] count_inc;
  logic             at_term;
  logic             counting;

  always_comb begin
    term_cnt = WIDTH'(7);
    half_cnt = WIDTH'(4);
    case (active_sel_q)
      2'd0: begin term_cnt = WIDTH'(1);  half_cnt = WIDTH'(1); end
      2'd1: begin term_cnt = WIDTH'(3);  half_cnt = WIDTH'(2); end
      2'd2: begin term_cnt = WIDTH'(7);  half_cnt = WIDTH'(4); end
      2'd3: begin term_cnt = WIDTH'(15); half_cnt = WIDTH'(8); end
      default: begin term_cnt = WIDTH'(7); half_cnt = WIDTH'(4); end
    endcase
  end

  assign at_term   = (count_q == term_cnt);
  assign count_inc = at_term ? '0 : count_q + WIDTH'(1);
  assign counting  = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    active_sel_d = active_sel_q;
    pending_d    = pending_q;
    case (state_q)
      ST_IDLE: begin
        count_d = '0;
        if (i_cfg_valid) active_sel_d = i_cfg_sel;
        if (i_enable)    state_d      = ST_RUN;
      end
      ST_RUN: begin
        count_d = count_inc;
        // A config request wins over a same-cycle disable; LOAD honours the disable later.
        if (i_cfg_valid) begin
          pending_d = i_cfg_sel;
          state_d   = ST_DRAIN;
        end else if (!i_enable && at_term) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        count_d = count_inc;
        if (at_term) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d      = '0;
        active_sel_d = pending_q;
        state_d      = i_enable ? ST_RUN : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
    // Ratio only changes when count_d is zero, so the current half point is always safe here.
    div_d = ((state_d == ST_RUN) || (state_d == ST_DRAIN)) && (count_d >= half_cnt);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      div_q        <= 1'b0;
      active_sel_q <= 2'd2;
      pending_q    <= 2'd2;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      div_q        <= div_d;
      active_sel_q <= active_sel_d;
      pending_q    <= pending_d;
    end
  end

  assign o_cfg_ready  = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign o_busy       = (state_q == ST_DRAIN) || (state_q == ST_LOAD);
  assign o_active_sel = active_sel_q;
  assign o_count      = count_q;
  assign o_count_end  = counting && at_term;
  assign o_div_clk    = div_q;

endmodule

// File: tb/tb_clkdiv_switch_ctrl.sv
// tb/tb_clkdiv_switch_ctrl.sv - directed and randomized checks against a behavioural divider model
module tb_clkdiv_switch_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       i_enable = 1'b0;
  logic       i_cfg_valid = 1'b0;
  logic [1:0] i_cfg_sel = 2'd0;
  logic       o_cfg_ready;
  logic       o_busy;
  logic [1:0] o_active_sel;
  logic [3:0] o_count;
  logic       o_count_end;
  logic       o_div_clk;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 idle, 1 run, 2 drain, 3 load
  int m_mode, m_sel, m_pend, m_cnt, m_div;

  clkdiv_switch_ctrl #(.WIDTH(4)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .i_enable     (i_enable),
    .i_cfg_valid  (i_cfg_valid),
    .i_cfg_sel    (i_cfg_sel),
    .o_cfg_ready  (o_cfg_ready),
    .o_busy       (o_busy),
    .o_active_sel (o_active_sel),
    .o_count      (o_count),
    .o_count_end  (o_count_end),
    .o_div_clk    (o_div_clk)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int period(input int sel);
    return 2 ** (sel + 1);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_sel = 2; m_pend = 2; m_cnt = 0; m_div = 0;
  endtask

  task automatic model_step(input int en, input int cv, input int cs);
    int n;
    n = period(m_sel);
    case (m_mode)
      0: begin
        if (cv != 0) m_sel = cs;
        m_mode = (en != 0) ? 1 : 0;
        m_cnt = 0; m_div = 0;
      end
      1: begin
        if (cv != 0) begin
          m_pend = cs; m_mode = 2;
        end else if (en == 0 && m_cnt == n - 1) begin
          m_mode = 0;
        end
        m_cnt = (m_cnt + 1) % n;
        m_div = (m_cnt >= n / 2) ? 1 : 0;
      end
      2: begin
        if (m_cnt == n - 1) begin
          m_mode = 3; m_cnt = 0; m_div = 0;
        end else begin
          m_cnt = m_cnt + 1;
          m_div = (m_cnt >= n / 2) ? 1 : 0;
        end
      end
      default: begin
        m_sel = m_pend;
        m_mode = (en != 0) ? 1 : 0;
        m_cnt = 0; m_div = 0;
      end
    endcase
  endtask

  task automatic compare_all();
    int n;
    n = period(m_sel);
    check("count",     int'(o_count),      m_cnt);
    check("div_clk",   int'(o_div_clk),    m_div);
    check("active_sel",int'(o_active_sel), m_sel);
    check("cfg_ready", int'(o_cfg_ready),  (m_mode <= 1) ? 1 : 0);
    check("busy",      int'(o_busy),       (m_mode >= 2) ? 1 : 0);
    check("count_end", int'(o_count_end),
          ((m_mode == 1 || m_mode == 2) && m_cnt == n - 1) ? 1 : 0);
  endtask

  // Inputs are applied just after a falling edge; outputs are compared at the next falling edge.
  task automatic step(input int en, input int cv, input int cs);
    i_enable    = (en != 0);
    i_cfg_valid = (cv != 0);
    i_cfg_sel   = 2'(cs);
    model_step(en, cv, cs);
    @(negedge clk);
    compare_all();
  endtask

  task automatic async_reset_mid_cycle();
    #2 resetn = 1'b0;
    #1 model_reset();
    compare_all();
    check("rst_sel", int'(o_active_sel), 2);
    @(negedge clk);
    compare_all();
    resetn = 1'b1;
  endtask

  initial begin
    int en_r;
    model_reset();
    @(negedge clk);
    compare_all();
    check("rst_count", int'(o_count), 0);
    resetn = 1'b1;

    // /8 free-running: 4 low / 4 high, end pulse at 7
    for (int k = 0; k < 20; k++) step(1, 0, 0);

    // switch to /2 from count 2
    for (int k = 0; k < 20 && m_cnt != 2; k++) step(1, 0, 0);
    check("sync_cnt2", int'(o_count), 2);
    step(1, 1, 0);
    check("drain_ready", int'(o_cfg_ready), 0);
    for (int k = 0; k < 14; k++) step(1, 0, 0);
    check("sel_after_switch", int'(o_active_sel), 0);

    // back to idle, load /8 without drain, then disable at count 5
    for (int k = 0; k < 6; k++) step(0, 0, 0);
    step(0, 1, 2);
    for (int k = 0; k < 20 && m_cnt != 5; k++) step(1, 0, 0);
    check("sync_cnt5", int'(o_count), 5);
    for (int k = 0; k < 4; k++) step(0, 0, 0);
    check("idle_after_disable", int'(o_count), 0);

    // request /4, pulse /16 during drain; /4 must win
    step(1, 0, 0);
    step(1, 1, 1);
    step(1, 1, 3);
    for (int k = 0; k < 12; k++) step(1, 0, 0);
    check("drain_cfg_ignored", int'(o_active_sel), 1);

    // same-cycle cfg and disable, then same-ratio request
    for (int k = 0; k < 3; k++) step(1, 0, 0);
    step(0, 1, 1);
    for (int k = 0; k < 8; k++) step(0, 0, 0);
    check("idle_after_load", int'(o_busy), 0);

    // /16 from idle
    step(0, 1, 3);
    for (int k = 0; k < 34; k++) step(1, 0, 0);
    check("sel16", int'(o_active_sel), 3);

    // reset in the middle of a drain
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    check("in_drain", int'(o_busy), 1);
    async_reset_mid_cycle();
    for (int k = 0; k < 10; k++) step(1, 0, 0);

    // randomized stretch
    en_r = 1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 24) == 0) en_r = 1 - en_r;
      if ($urandom_range(0, 399) == 0) async_reset_mid_cycle();
      else step(en_r, ($urandom_range(0, 11) == 0) ? 1 : 0, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
